// File: rtl/asynchronous_d_ff.sv
// Reference register pair: q1 clears asynchronously, q2 clears synchronously.
// Both capture the same data input on the rising clock edge.
`timescale 1ns / 1ps

module asynchronous_d_ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;
    logic [WIDTH-1:0] q2_d;

    // RST in the sensitivity list lets q1 clear without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            q1_q <= RESET_VALUE;
        end else begin
            q1_q <= D;
        end
    end

    // RST is only looked at through this mux, so it takes effect on the next edge.
    always_comb begin
        q2_d = RST ? RESET_VALUE : D;
    end

    always_ff @(posedge CLK) begin
        q2_q <= q2_d;
    end

    assign Q1 = q1_q;
    assign Q2 = q2_q;

endmodule

// File: tb/tb_asynchronous_d_ff.sv
// Bench for asynchronous_d_ff: directed timeline with a queue-based scoreboard
// whose monitor compares both outputs whenever an expectation is posted.
`timescale 1ns / 1ps

module tb_asynchronous_d_ff;

    typedef struct {
        string name;
        logic  q1;
        logic  q2;
    } exp_t;

    logic CLK;
    logic RST;
    logic D;
    logic Q1;
    logic Q2;

    exp_t exp_q[$];
    int   pushed  = 0;
    int   popped  = 0;
    int   checks  = 0;
    int   errors  = 0;

    asynchronous_d_ff #(
        .WIDTH      (1),
        .RESET_VALUE(1'b0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .D  (D),
        .Q1 (Q1),
        .Q2 (Q2)
    );

    // Rising edges at 10, 30, 50, ... ns.
    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic expect_at(input realtime t, input string name,
                             input logic q1, input logic q2);
        exp_t e;
        wait_until(t);
        e.name = name;
        e.q1   = q1;
        e.q2   = q2;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: pops each posted expectation and compares the live outputs.
    initial begin
        exp_t e;
        forever begin
            wait (pushed > popped);
            e = exp_q.pop_front();
            popped++;
            check({e.name, ".q1"}, Q1, e.q1);
            check({e.name, ".q2"}, Q2, e.q2);
        end
    end

    initial begin
        RST = 1'b1;
        D   = 1'b0;

        // Power-up: q1 cleared immediately; q2 defined after the 10 ns edge.
        wait_until(5);
        checks++;
        if (Q1 !== 1'b0) begin
            errors++;
            $display("FAIL powerup_async.q1 at %0t: got %b, expected 0", $time, Q1);
        end
        expect_at(20, "powerup_edge", 1'b0, 1'b0);
        wait_until(25);  RST = 1'b0;
        expect_at(35, "release_capture0", 1'b0, 1'b0);

        // Capture a 1 then a 0.
        wait_until(45);  D = 1'b1;
        expect_at(55, "capture1", 1'b1, 1'b1);
        wait_until(65);  D = 1'b0;
        expect_at(75, "capture0", 1'b0, 1'b0);

        // Mid-cycle reset: q1 clears now, q2 at the next edge.
        wait_until(105); D = 1'b1;
        expect_at(115, "pre_reset", 1'b1, 1'b1);
        wait_until(120); RST = 1'b1;
        expect_at(122, "midcycle_reset", 1'b0, 1'b1);
        expect_at(135, "reset_after_edge", 1'b0, 1'b0);

        // Release and re-capture.
        wait_until(140); RST = 1'b0;
        expect_at(145, "released_no_edge", 1'b0, 1'b0);
        expect_at(155, "recapture", 1'b1, 1'b1);

        // 3 ns glitch between edges: q2 must not see it.
        wait_until(160); RST = 1'b1;
        expect_at(161, "glitch_during", 1'b0, 1'b1);
        wait_until(163); RST = 1'b0;
        expect_at(165, "glitch_after", 1'b0, 1'b1);
        expect_at(175, "glitch_recapture", 1'b1, 1'b1);

        // D change between edges stays invisible until the next edge.
        wait_until(180); D = 1'b0;
        expect_at(185, "d_between_edges", 1'b1, 1'b1);
        expect_at(195, "d_next_edge", 1'b0, 1'b0);

        // Reset held across edges with D = 1, then released at the 230 ns edge.
        wait_until(200); RST = 1'b1;
        expect_at(201, "reassert", 1'b0, 1'b0);
        wait_until(205); D = 1'b1;
        expect_at(215, "held_reset_edge", 1'b0, 1'b0);
        wait_until(230.001); RST = 1'b0;
        expect_at(235, "coincident_release", 1'b0, 1'b0);
        expect_at(255, "after_coincident", 1'b1, 1'b1);

        // Drain the scoreboard with a bounded wait.
        fork
            wait (popped == pushed);
            #100;
        join_any
        disable fork;
        if (popped != pushed) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d compared, expected %0d", popped, pushed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
